start_fifo_srl_ctrl: RTL and testbench

//  Start-token FIFO that sits directly upstream of the shift-register storage in each

---
 rtl/start_fifo_srl_ctrl_if.sv | 47 ++++
 rtl/start_fifo_srl_ctrl.sv | 87 ++++++++
 tb/tb_start_fifo_srl_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/start_fifo_srl_ctrl_if.sv
// Purpose : handshake bundle between a start-token producer/consumer pair and the FIFO.
// Ports   : if_write_ce/if_write/if_din and if_read_ce/if_read in; if_full_n/if_empty_n/if_dout out
//           (count out when START_FIFO_COUNT_EN is defined); master = user side, slave = FIFO side.
interface start_fifo_srl_ctrl_if #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1
);
    logic                  if_full_n;
    logic                  if_write_ce;
    logic                  if_write;
    logic [DATA_WIDTH-1:0] if_din;
    logic                  if_empty_n;
    logic                  if_read_ce;
    logic                  if_read;
    logic [DATA_WIDTH-1:0] if_dout;
`ifdef START_FIFO_COUNT_EN
    logic [ADDR_WIDTH:0]   count;
`endif

    modport master (
        input  if_full_n,
        output if_write_ce,
        output if_write,
        output if_din,
        input  if_empty_n,
        output if_read_ce,
        output if_read,
        input  if_dout
`ifdef START_FIFO_COUNT_EN
       ,input  count
`endif
    );

    modport slave (
        output if_full_n,
        input  if_write_ce,
        input  if_write,
        input  if_din,
        output if_empty_n,
        input  if_read_ce,
        input  if_read,
        output if_dout
`ifdef START_FIFO_COUNT_EN
       ,output count
`endif
    );
endinterface

// File: rtl/start_fifo_srl_ctrl.sv
// Purpose : start-token FIFO controller over shift-register storage, ap_fifo style flags.
// Latency : write to empty -> empty_n/dout valid next cycle; flags are registered, no comb input->flag path.
// Backpressure: full_n=0 blocks writes, empty_n=0 blocks reads; blocked requests change nothing.
// Ports   : clk, reset_n (async active-low), fifo (slave modport of start_fifo_srl_ctrl_if).
// Option  : START_FIFO_COUNT_EN adds a registered occupancy output 'count' (0..DEPTH).
module start_fifo_srl_ctrl #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    start_fifo_srl_ctrl_if.slave fifo
);
    localparam int PW    = ADDR_WIDTH + 1;
    localparam int SLOTS = 2 ** ADDR_WIDTH;

    // ptr holds occupancy-1; all-ones means empty. The oldest token sits at SRL[ptr].
    logic [PW-1:0]         ptr;
    logic                  full_n_q;
    logic                  empty_n_q;
    logic [DATA_WIDTH-1:0] srl [SLOTS];

    logic push;
    logic pop;

    assign push = fifo.if_write & fifo.if_write_ce & full_n_q;
    assign pop  = fifo.if_read  & fifo.if_read_ce  & empty_n_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr       <= '1;
            full_n_q  <= 1'b1;
            empty_n_q <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    ptr       <= ptr + PW'(1);
                    empty_n_q <= 1'b1;
                    full_n_q  <= (ptr != PW'(DEPTH - 2));
                end
                2'b01: begin
                    ptr       <= ptr - PW'(1);
                    full_n_q  <= 1'b1;
                    empty_n_q <= (ptr != '0);
                end
                // Simultaneous push and pop: the shift moves the next-oldest token into
                // slot ptr, so the pointer and flags stay put.
                default: ;
            endcase
        end
    end

    // Storage is deliberately not reset; contents are only meaningful below ptr.
    always_ff @(posedge clk) begin
        if (push) begin
            for (int i = SLOTS - 1; i > 0; i--) begin
                srl[i] <= srl[i-1];
            end
            srl[0] <= fifo.if_din;
        end
    end

    assign fifo.if_dout    = srl[ptr[ADDR_WIDTH-1:0]];
    assign fifo.if_full_n  = full_n_q;
    assign fifo.if_empty_n = empty_n_q;

`ifdef START_FIFO_COUNT_EN
    // Separate register so count is a clean flop output, tracking ptr+1.
    logic [PW-1:0] count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count_q <= count_q + PW'(1);
                2'b01:   count_q <= count_q - PW'(1);
                default: ;
            endcase
        end
    end

    assign fifo.count = count_q;
`endif

endmodule

// File: tb/tb_start_fifo_srl_ctrl.sv
// Purpose : self-checking bench: directed vector table on a DEPTH=2 instance, random
//           scoreboard run on a DEPTH=4 instance, asynchronous reset checks on both.
// Ports   : none (top-level bench).
module tb_start_fifo_srl_ctrl;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    start_fifo_srl_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(1)) if2 ();
    start_fifo_srl_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) if4 ();

    start_fifo_srl_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(1), .DEPTH(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .fifo(if2.slave));
    start_fifo_srl_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .fifo(if4.slave));

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic       wr;
        logic       wce;
        logic [7:0] din;
        logic       rd;
        logic       rce;
        logic       full_n;
        logic       empty_n;
        logic       chk_dout;
        logic [7:0] dout;
        int         cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic wr, logic wce, logic [7:0] din, logic rd, logic rce,
                                logic full_n, logic empty_n, logic chk_dout,
                                logic [7:0] dout, int cnt);
        vec_t v;
        v.wr = wr; v.wce = wce; v.din = din; v.rd = rd; v.rce = rce;
        v.full_n = full_n; v.empty_n = empty_n; v.chk_dout = chk_dout;
        v.dout = dout; v.cnt = cnt;
        return v;
    endfunction

    task automatic drive2(input logic wr, input logic wce, input logic [7:0] din,
                          input logic rd, input logic rce);
        if2.if_write = wr; if2.if_write_ce = wce; if2.if_din = din;
        if2.if_read = rd;  if2.if_read_ce = rce;
    endtask

    task automatic check2(input string tag, input logic full_n, input logic empty_n,
                          input logic chk_dout, input logic [7:0] dout, input int cnt);
        check({tag, "_full_n"},  32'(if2.if_full_n),  32'(full_n));
        check({tag, "_empty_n"}, 32'(if2.if_empty_n), 32'(empty_n));
        if (chk_dout) check({tag, "_dout"}, 32'(if2.if_dout), 32'(dout));
`ifdef START_FIFO_COUNT_EN
        check({tag, "_count"}, 32'(if2.count), 32'(cnt));
`else
        if (cnt < 0) $display("negative count in table for %s", tag);
`endif
    endtask

    // Reference model for the DEPTH=4 instance.
    logic [7:0] q[$];

    task automatic check4(input string tag);
        check({tag, "_full_n"},  32'(if4.if_full_n),  32'(q.size() != 4));
        check({tag, "_empty_n"}, 32'(if4.if_empty_n), 32'(q.size() != 0));
        if (q.size() != 0) check({tag, "_dout"}, 32'(if4.if_dout), 32'(q[0]));
`ifdef START_FIFO_COUNT_EN
        check({tag, "_count"}, 32'(if4.count), 32'(q.size()));
`endif
    endtask

    initial begin
        drive2(0, 0, 8'h00, 0, 0);
        if4.if_write = 0; if4.if_write_ce = 0; if4.if_din = 8'h00;
        if4.if_read = 0;  if4.if_read_ce = 0;

        // Asynchronous reset asserted between clock edges.
        #3 reset_n = 1'b0;
        #1;
        check2("rst", 1'b1, 1'b0, 1'b0, 8'h00, 0);
        check4("rst4");
        @(negedge clk) reset_n = 1'b1;

        //          wr wce din    rd rce  full empty chk dout  cnt
        vecs.push_back(mk(1, 1, 8'hA5, 0, 0, 1, 1, 1, 8'hA5, 1));
        vecs.push_back(mk(1, 1, 8'h3C, 0, 0, 0, 1, 1, 8'hA5, 2));
        vecs.push_back(mk(1, 1, 8'hFF, 0, 0, 0, 1, 1, 8'hA5, 2)); // write while full
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 1, 1, 8'h3C, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 0, 0, 8'h00, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 0, 0, 8'h00, 0)); // read while empty
        vecs.push_back(mk(1, 1, 8'h11, 0, 0, 1, 1, 1, 8'h11, 1));
        vecs.push_back(mk(1, 1, 8'h22, 1, 1, 1, 1, 1, 8'h22, 1)); // push & pop at occ 1
        vecs.push_back(mk(1, 0, 8'h99, 0, 0, 1, 1, 1, 8'h22, 1)); // write_ce low x3
        vecs.push_back(mk(1, 0, 8'h99, 0, 0, 1, 1, 1, 8'h22, 1));
        vecs.push_back(mk(1, 0, 8'h99, 0, 0, 1, 1, 1, 8'h22, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1, 1, 1, 8'h22, 1)); // read_ce low
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 0, 0, 8'h00, 0));
        vecs.push_back(mk(1, 1, 8'h44, 0, 0, 1, 1, 1, 8'h44, 1));
        vecs.push_back(mk(1, 1, 8'h55, 0, 0, 0, 1, 1, 8'h44, 2));
        vecs.push_back(mk(1, 1, 8'h66, 1, 1, 1, 1, 1, 8'h55, 1)); // full: only pop happens
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 0, 0, 8'h00, 0));
        vecs.push_back(mk(1, 1, 8'h77, 1, 1, 1, 1, 1, 8'h77, 1)); // empty: only push happens
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 0, 0, 8'h00, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive2(vecs[i].wr, vecs[i].wce, vecs[i].din, vecs[i].rd, vecs[i].rce);
            @(posedge clk);
            #1;
            check2($sformatf("vec%0d", i), vecs[i].full_n, vecs[i].empty_n,
                   vecs[i].chk_dout, vecs[i].dout, vecs[i].cnt);
        end

        // Fill, then reset mid-cycle: tokens discarded, flags return at once.
        @(negedge clk) drive2(1, 1, 8'h88, 0, 0);
        @(negedge clk) drive2(1, 1, 8'h99, 0, 0);
        @(posedge clk);
        #1 check2("fill", 1'b0, 1'b1, 1'b1, 8'h88, 2);
        #1 reset_n = 1'b0;
        #1 check2("midrst", 1'b1, 1'b0, 1'b0, 8'h00, 0);
        @(negedge clk);
        drive2(0, 0, 8'h00, 0, 0);
        reset_n = 1'b1;
        @(negedge clk) drive2(1, 1, 8'hAB, 0, 0);
        @(posedge clk);
        #1 check2("postrst", 1'b1, 1'b1, 1'b1, 8'hAB, 1);
        @(negedge clk) drive2(0, 0, 8'h00, 0, 0);

        // Random traffic on the DEPTH=4 instance against the queue model.
        begin
            int wthr;
            int rthr;
            logic push_m;
            logic pop_m;
            wthr = 50;
            rthr = 50;
            for (int c = 0; c < 10000; c++) begin
                if (c % 500 == 0) begin
                    wthr = $urandom_range(20, 90);
                    rthr = $urandom_range(20, 90);
                end
                @(negedge clk);
                if4.if_write    = ($urandom_range(0, 99) < wthr);
                if4.if_write_ce = ($urandom_range(0, 9) != 0);
                if4.if_din      = 8'($urandom);
                if4.if_read     = ($urandom_range(0, 99) < rthr);
                if4.if_read_ce  = ($urandom_range(0, 9) != 0);
                push_m = if4.if_write & if4.if_write_ce & (q.size() < 4);
                pop_m  = if4.if_read  & if4.if_read_ce  & (q.size() > 0);
                @(posedge clk);
                if (pop_m)  void'(q.pop_front());
                if (push_m) q.push_back(if4.if_din);
                #1 check4($sformatf("rnd%0d", c));
                if (c == 5000) begin
                    #1 reset_n = 1'b0;
                    q.delete();
                    #1 check4("rnd_rst");
                    @(negedge clk) reset_n = 1'b1;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
